ptr_seq_collect: RTL and testbench
==================================

// Module: ptr_seq_collect
// PURPOSE
//  Receive end of the pointer-sequence stream (out_ptr/out_ptr_vld as produced by ptr_seq_gen).
//  Rebuilds the linked-list next table and the list heads from observed sequences.
//  Drains the table as (ptr, next) write pairs, the same form the init writer feeds the chaser.
//  Used as a scoreboard and loopback source: the dump can re-initialise a chaser memory.
// PARAMETERS
//  N      16              number of list nodes; index 0 is the null pointer
//  WIDTH  $clog2(N)       pointer width
//  HEADS  8               head FIFO depth (max lists held between flushes)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_ptr     in   WIDTH  stream pointer
//  in_vld     in   1      in_ptr valid; a list ends on the first cycle with in_vld low
//  flush      in   1      single-cycle pulse: close the open list, then drain the table
//  dump_ptr   out  WIDTH  node index of the current pair
//  dump_next  out  WIDTH  successor of dump_ptr (0 = tail)
//  dump_vld   out  1      pair valid
//  dump_rdy   in   1      consumer accepts the pair when dump_vld & dump_rdy
//  head_ptr   out  WIDTH  oldest recorded list head
//  head_vld   out  1      head FIFO not empty
//  head_rdy   in   1      pop when head_vld & head_rdy
//  list_cnt   out  8      completed lists since reset/last done; wraps mod 256
//  err_zero   out  1      sticky: in_vld seen with in_ptr==0
//  err_dup    out  1      sticky: pointer already seen since last drain
//  err_ovf    out  1      sticky: list started while head FIFO full
//  err_drop   out  1      sticky: in_vld high during a flush cycle or in DRAIN
//  busy       out  1      state==DRAIN
//  done       out  1      one-cycle pulse when the drain completes
// BEHAVIOUR
//  Reset: state=IDLE; seen[], next[], head FIFO, list_cnt, err_* cleared; all valids, busy and done 0.
//  Storage: next[N] x WIDTH; seen[N] bitmap; prev register; head FIFO of HEADS entries.
//  IDLE:   in_vld & in_ptr!=0 & !seen[in_ptr] -> push head, seen<=1, prev<=in_ptr -> COLLECT.
//          If the FIFO is full (after a same-cycle pop): err_ovf<=1 -> SKIP.
//  COLLECT: in_vld with a valid ptr -> next[prev]<=in_ptr, seen<=1, prev<=in_ptr.
//          in_vld low -> next[prev]<=0, list_cnt++ -> IDLE.
//  SKIP:   ignore input until in_vld is low -> IDLE. The dropped list is not counted.
//  In any state, in_ptr==0 -> err_zero<=1, item ignored, list not ended.
//  seen[in_ptr]==1 -> err_dup<=1, item ignored, prev unchanged.
//  flush (not in DRAIN) has priority over input in the same cycle.
//  In COLLECT, flush terminates the list (next[prev]<=0, list_cnt++). In-cycle in_vld -> err_drop.
//  flush -> DRAIN next cycle with idx=1.
//  DRAIN:  dump_vld = seen[idx] (combinational), dump_ptr=idx, dump_next=next[idx].
//          idx advances when !seen[idx] (skip, 1/cycle) or on accept.
//          Pair is held stable while dump_rdy is low. Order is ascending idx, 1..N-1.
//  Last idx retired -> done=1 for 1 cycle; seen/next cleared; list_cnt<=0; state -> IDLE.
//  Head FIFO is independent of DRAIN: head_vld = !empty, pops anytime. Full+pop+push is legal.
//  flush while in DRAIN is ignored. Input in DRAIN is ignored and sets err_drop.
//  Errors clear only on rst.
//  Drain latency: (N-1) + stalled cycles after the flush cycle.
//  rst mid-drain aborts the drain: no done pulse; all state returns to reset values.
// TESTING
//  1. Lists 1,5,3,10 | 2,4 | 6 | 7,15,8 | 9,14,11,13,12, one idle cycle between each; flush; dump_rdy=1
//     -> pairs (1,5)(2,4)(3,10)(4,0)(5,3)(6,0)(7,15)(8,0)(9,14)(10,0)(11,13)(12,0)(13,12)(14,11)(15,8)
//     on 15 consecutive cycles; heads 1,2,6,7,9; list_cnt=5 before done; done 1 cycle after (15,8).
//  2. Same input, dump_rdy toggling 1010... -> identical pair order; each pair held while rdy=0.
//  3. Stream 1,5,5,3 then idle -> err_dup=1; dump (1,5)(3,0)(5,3); list_cnt=1.
//  4. in_vld with in_ptr=0 mid-list 2,0,4 -> err_zero=1; dump (2,4)(4,0).
//  5. HEADS=8: nine single-node lists 1..9, no head pops -> err_ovf=1, list_cnt=8.
//     Node 9 is absent from the dump; heads 1..8.
//  6. Stream 7,15 then flush with in_vld=1 (ptr 8) -> err_drop=1; dump (7,15)(15,0).
//     Assert rst mid-drain -> dump_vld=0, busy=0, no done pulse, head_vld=0.

Source files
------------

// File: rtl/ptr_seq_collect.sv
// ptr_seq_collect
// Receive end of the pointer-sequence stream. Rebuilds the linked-list next
// table and the list heads from the observed sequences, then drains the table
// as (ptr, next) pairs in ascending node order so the dump can re-initialise a
// chaser memory.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   in_ptr, in_vld            incoming stream; a list ends on the first cycle with in_vld low
//   flush                     pulse: close the open list, then drain the table
//   dump_ptr/next/vld/rdy     drained (node, successor) pairs, valid/ready handshake
//   head_ptr/vld/rdy          FIFO of recorded list heads, popped on vld & rdy
//   list_cnt                  lists completed since reset or the last drain
//   err_zero/dup/ovf/drop     sticky error flags, cleared only by rst
//   busy, done                drain in progress, one-cycle drain-complete pulse
module ptr_seq_collect #(
    parameter int N     = 16,
    parameter int WIDTH = $clog2(N),
    parameter int HEADS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_ptr,
    input  logic             in_vld,
    input  logic             flush,
    output logic [WIDTH-1:0] dump_ptr,
    output logic [WIDTH-1:0] dump_next,
    output logic             dump_vld,
    input  logic             dump_rdy,
    output logic [WIDTH-1:0] head_ptr,
    output logic             head_vld,
    input  logic             head_rdy,
    output logic [7:0]       list_cnt,
    output logic             err_zero,
    output logic             err_dup,
    output logic             err_ovf,
    output logic             err_drop,
    output logic             busy,
    output logic             done
);

    // Head FIFO pointers wrap naturally, so HEADS is expected to be a power of two.
    localparam int HW = $clog2(HEADS);
    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(N - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, SKIP, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [N-1:0]     seen_q;
    logic [WIDTH-1:0] nextTab_q [N];
    logic [7:0]       listCnt_q;
    logic [WIDTH-1:0] headMem_q [HEADS];
    logic [HW-1:0]    headWr_q, headRd_q;
    logic [HW:0]      headCnt_q;
    logic             errZero_q, errDup_q, errOvf_q, errDrop_q;
    logic             done_q;

    logic             itemZero, itemDup, itemOk;
    logic             headPush, headPop, headFull;
    logic             seenWe, nextWe, listInc, drainDone;
    logic [WIDTH-1:0] nextAddr, nextData;
    logic             setZero, setDup, setOvf, setDrop;

    assign headPop  = head_vld && head_rdy;
    assign headFull = (headCnt_q == (HW+1)'(HEADS));
    assign itemZero = in_vld && (in_ptr == '0);
    assign itemDup  = in_vld && (in_ptr != '0) && seen_q[in_ptr];
    assign itemOk   = in_vld && (in_ptr != '0) && !seen_q[in_ptr];

    // Next-state and table-update decode. Flush outranks stream input; a zero
    // or already-seen pointer is dropped without ending the current list. A
    // list start with a full head FIFO (after any same-cycle pop) is skipped.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        idx_d     = idx_q;
        seenWe    = 1'b0;
        nextWe    = 1'b0;
        nextAddr  = prev_q;
        nextData  = '0;
        headPush  = 1'b0;
        listInc   = 1'b0;
        drainDone = 1'b0;
        setZero   = 1'b0;
        setDup    = 1'b0;
        setOvf    = 1'b0;
        setDrop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    setDrop = in_vld;
                    idx_d   = WIDTH'(1);
                    state_d = DRAIN;
                end else if (itemZero) begin
                    setZero = 1'b1;
                end else if (itemDup) begin
                    setDup = 1'b1;
                end else if (itemOk) begin
                    if (headFull && !headPop) begin
                        setOvf  = 1'b1;
                        state_d = SKIP;
                    end else begin
                        headPush = 1'b1;
                        seenWe   = 1'b1;
                        prev_d   = in_ptr;
                        state_d  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (flush) begin
                    nextWe  = 1'b1;
                    listInc = 1'b1;
                    setDrop = in_vld;
                    idx_d   = WIDTH'(1);
                    state_d = DRAIN;
                end else if (!in_vld) begin
                    nextWe  = 1'b1;
                    listInc = 1'b1;
                    state_d = IDLE;
                end else if (itemZero) begin
                    setZero = 1'b1;
                end else if (itemDup) begin
                    setDup = 1'b1;
                end else begin
                    nextWe   = 1'b1;
                    nextData = in_ptr;
                    seenWe   = 1'b1;
                    prev_d   = in_ptr;
                end
            end
            SKIP: begin
                if (flush) begin
                    setDrop = in_vld;
                    idx_d   = WIDTH'(1);
                    state_d = DRAIN;
                end else if (!in_vld) begin
                    state_d = IDLE;
                end else if (itemZero) begin
                    setZero = 1'b1;
                end
            end
            DRAIN: begin
                setDrop = in_vld;
                // Unused nodes retire at one per cycle; used ones wait for the consumer.
                if (!seen_q[idx_q] || dump_rdy) begin
                    if (idx_q == LAST_IDX) begin
                        drainDone = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        idx_d = idx_q + WIDTH'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers and the registered drain-complete pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            idx_q   <= idx_d;
            done_q  <= drainDone;
        end
    end

    // Linked-list table, seen bitmap and list counter; all wiped when a drain completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || drainDone) begin
            seen_q    <= '0;
            listCnt_q <= '0;
            for (int i = 0; i < N; i++) nextTab_q[i] <= '0;
        end else begin
            if (seenWe)  seen_q[in_ptr]      <= 1'b1;
            if (nextWe)  nextTab_q[nextAddr] <= nextData;
            if (listInc) listCnt_q           <= listCnt_q + 8'd1;
        end
    end

    // Head FIFO runs independently of the drain; push and pop may coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headWr_q  <= '0;
            headRd_q  <= '0;
            headCnt_q <= '0;
            for (int i = 0; i < HEADS; i++) headMem_q[i] <= '0;
        end else begin
            if (headPush) begin
                headMem_q[headWr_q] <= in_ptr;
                headWr_q            <= headWr_q + HW'(1);
            end
            if (headPop) headRd_q <= headRd_q + HW'(1);
            case ({headPush, headPop})
                2'b10:   headCnt_q <= headCnt_q + (HW+1)'(1);
                2'b01:   headCnt_q <= headCnt_q - (HW+1)'(1);
                default: headCnt_q <= headCnt_q;
            endcase
        end
    end

    // Sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errZero_q <= 1'b0;
            errDup_q  <= 1'b0;
            errOvf_q  <= 1'b0;
            errDrop_q <= 1'b0;
        end else begin
            errZero_q <= errZero_q | setZero;
            errDup_q  <= errDup_q  | setDup;
            errOvf_q  <= errOvf_q  | setOvf;
            errDrop_q <= errDrop_q | setDrop;
        end
    end

    assign busy      = (state_q == DRAIN);
    assign dump_vld  = busy && seen_q[idx_q];
    assign dump_ptr  = idx_q;
    assign dump_next = nextTab_q[idx_q];
    assign head_ptr  = headMem_q[headRd_q];
    assign head_vld  = (headCnt_q != '0);
    assign list_cnt  = listCnt_q;
    assign err_zero  = errZero_q;
    assign err_dup   = errDup_q;
    assign err_ovf   = errOvf_q;
    assign err_drop  = errDrop_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ptr_seq_collect.sv
// tb_ptr_seq_collect
// Scenario tasks drive lists into ptr_seq_collect, queue the expected dump
// pairs and heads, then drain the table and compare what the DUT emits.
module tb_ptr_seq_collect;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_ptr;
    logic       in_vld, flush, dump_rdy, head_rdy;
    logic [3:0] dump_ptr, dump_next, head_ptr;
    logic       dump_vld, head_vld;
    logic [7:0] list_cnt;
    logic       err_zero, err_dup, err_ovf, err_drop, busy, done;

    int nVec  = 0;
    int nMiss = 0;

    logic [7:0] expQ[$];
    logic [7:0] accQ[$];
    logic [7:0] obsQ[$];
    logic       obsRdy[$];
    int         accCyc[$];
    logic [3:0] expHeads[$];
    int         stim[$];
    int         doneAt, lcBefore, lcAtDone;

    ptr_seq_collect #(.N(16), .WIDTH(4), .HEADS(8)) dut (
        .clk(clk), .rst(rst), .in_ptr(in_ptr), .in_vld(in_vld), .flush(flush),
        .dump_ptr(dump_ptr), .dump_next(dump_next), .dump_vld(dump_vld), .dump_rdy(dump_rdy),
        .head_ptr(head_ptr), .head_vld(head_vld), .head_rdy(head_rdy),
        .list_cnt(list_cnt), .err_zero(err_zero), .err_dup(err_dup), .err_ovf(err_ovf),
        .err_drop(err_drop), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Send the pointers in stim on consecutive cycles, optionally followed by
    // the idle cycle that ends the list.
    task automatic sendStim(input bit endIdle);
        foreach (stim[i]) begin
            in_vld = 1'b1;
            in_ptr = 4'(stim[i]);
            @(negedge clk);
        end
        if (endIdle) begin
            in_vld = 1'b0;
            in_ptr = '0;
            @(negedge clk);
        end
    endtask

    // Pulse flush, then record every offered and accepted pair until done or the budget runs out.
    task automatic drainCollect(input bit toggle, input int budget);
        flush = 1'b1;
        @(negedge clk);
        flush  = 1'b0;
        in_vld = 1'b0;
        in_ptr = '0;
        accQ.delete(); obsQ.delete(); obsRdy.delete(); accCyc.delete();
        doneAt = -1; lcBefore = -1; lcAtDone = -1;
        for (int c = 0; c < budget; c++) begin
            dump_rdy = toggle ? (c % 2 == 0) : 1'b1;
            if (done) begin
                doneAt   = c;
                lcAtDone = list_cnt;
                break;
            end
            if (dump_vld) begin
                obsQ.push_back({dump_ptr, dump_next});
                obsRdy.push_back(dump_rdy);
                if (dump_rdy) begin
                    accQ.push_back({dump_ptr, dump_next});
                    accCyc.push_back(c);
                end
            end
            lcBefore = list_cnt;
            @(negedge clk);
        end
        dump_rdy = 1'b0;
    endtask

    task automatic popHead(output logic v, output logic [3:0] p);
        v = head_vld;
        p = head_ptr;
        head_rdy = 1'b1;
        @(negedge clk);
        head_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 0; in_ptr = 0; flush = 0; dump_rdy = 0; head_rdy = 0;
        repeat (2) @(negedge clk);
        nVec++; if (busy !== 1'b0) begin nMiss++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
        nVec++; if (dump_vld !== 1'b0) begin nMiss++; $display("[TB] FAIL reset dump_vld: got %b want 0", dump_vld); end
        nVec++; if (head_vld !== 1'b0) begin nMiss++; $display("[TB] FAIL reset head_vld: got %b want 0", head_vld); end
        nVec++; if (list_cnt !== 8'd0) begin nMiss++; $display("[TB] FAIL reset list_cnt: got %0d want 0", list_cnt); end
        nVec++; if ({err_zero, err_dup, err_ovf, err_drop} !== 4'b0) begin
            nMiss++; $display("[TB] FAIL reset errs: got %b want 0000", {err_zero, err_dup, err_ovf, err_drop});
        end
        rst = 1'b0;
        @(negedge clk);
        nVec++; if (done !== 1'b0) begin nMiss++; $display("[TB] FAIL reset done: got %b want 0", done); end
    endtask

    // Five lists, drained either at full rate or with dump_rdy toggling.
    task automatic test_lists(input bit toggle);
        logic [7:0] e, a;
        logic v;
        logic [3:0] p, eh;
        stim = '{1, 5, 3, 10};      expHeads.push_back(4'd1); sendStim(1);
        stim = '{2, 4};             expHeads.push_back(4'd2); sendStim(1);
        stim = '{6};                expHeads.push_back(4'd6); sendStim(1);
        stim = '{7, 15, 8};         expHeads.push_back(4'd7); sendStim(1);
        stim = '{9, 14, 11, 13, 12}; expHeads.push_back(4'd9); sendStim(1);
        expQ = '{8'h15, 8'h24, 8'h3A, 8'h40, 8'h53, 8'h60, 8'h7F, 8'h80,
                 8'h9E, 8'hA0, 8'hBD, 8'hC0, 8'hDC, 8'hEB, 8'hF8};
        drainCollect(toggle, 100);
        nVec++; if (lcBefore !== 5) begin nMiss++; $display("[TB] FAIL list_cnt before done: got %0d want 5", lcBefore); end
        nVec++; if (lcAtDone !== 0) begin nMiss++; $display("[TB] FAIL list_cnt at done: got %0d want 0", lcAtDone); end
        nVec++; if (doneAt !== (toggle ? 29 : 15)) begin
            nMiss++; $display("[TB] FAIL done cycle: got %0d want %0d", doneAt, toggle ? 29 : 15);
        end
        if (!toggle) begin
            nVec++;
            if (accCyc.size() != 15 || accCyc[0] != 0 || accCyc[14] != 14) begin
                nMiss++; $display("[TB] FAIL consecutive pairs: got %0d accepts want 15 on cycles 0..14", accCyc.size());
            end
        end else begin
            for (int i = 0; i + 1 < obsQ.size(); i++) begin
                if (!obsRdy[i]) begin
                    nVec++;
                    if (obsQ[i + 1] !== obsQ[i]) begin
                        nMiss++; $display("[TB] FAIL hold pair: got %h want %h", obsQ[i + 1], obsQ[i]);
                    end
                end
            end
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nVec++;
            if (accQ.size() == 0) begin nMiss++; $display("[TB] FAIL pair: got none want %h", e); end
            else begin
                a = accQ.pop_front();
                if (a !== e) begin nMiss++; $display("[TB] FAIL pair: got %h want %h", a, e); end
            end
        end
        nVec++; if (accQ.size() != 0) begin nMiss++; $display("[TB] FAIL extra pairs: got %0d want 0", accQ.size()); end
        while (expHeads.size() > 0) begin
            eh = expHeads.pop_front();
            popHead(v, p);
            nVec++;
            if (v !== 1'b1 || p !== eh) begin nMiss++; $display("[TB] FAIL head: got vld=%b ptr=%0d want ptr=%0d", v, p, eh); end
        end
        nVec++; if (head_vld !== 1'b0) begin nMiss++; $display("[TB] FAIL head empty: got %b want 0", head_vld); end
    endtask

    // Short scenarios sharing the drain/compare flow; kind selects dup, zero, ovf or drop.
    task automatic test_errors(input int kind);
        logic [7:0] e, a;
        logic v;
        logic [3:0] p, eh;
        case (kind)
            0: begin
                stim = '{1, 5, 5, 3}; expHeads.push_back(4'd1); sendStim(1);
                nVec++; if (list_cnt !== 8'd1) begin nMiss++; $display("[TB] FAIL dup list_cnt: got %0d want 1", list_cnt); end
                nVec++; if (err_dup !== 1'b1) begin nMiss++; $display("[TB] FAIL err_dup: got %b want 1", err_dup); end
                expQ = '{8'h15, 8'h30, 8'h53};
            end
            1: begin
                nVec++; if (err_zero !== 1'b0) begin nMiss++; $display("[TB] FAIL err_zero early: got %b want 0", err_zero); end
                stim = '{2, 0, 4}; expHeads.push_back(4'd2); sendStim(1);
                nVec++; if (err_zero !== 1'b1) begin nMiss++; $display("[TB] FAIL err_zero: got %b want 1", err_zero); end
                expQ = '{8'h24, 8'h40};
            end
            2: begin
                nVec++; if (err_ovf !== 1'b0) begin nMiss++; $display("[TB] FAIL err_ovf early: got %b want 0", err_ovf); end
                for (int i = 1; i <= 9; i++) begin
                    stim = '{i};
                    if (i <= 8) begin
                        expHeads.push_back(4'(i));
                        expQ.push_back({4'(i), 4'd0});
                    end
                    sendStim(1);
                end
                nVec++; if (err_ovf !== 1'b1) begin nMiss++; $display("[TB] FAIL err_ovf: got %b want 1", err_ovf); end
                nVec++; if (list_cnt !== 8'd8) begin nMiss++; $display("[TB] FAIL ovf list_cnt: got %0d want 8", list_cnt); end
            end
            default: begin
                nVec++; if (err_drop !== 1'b0) begin nMiss++; $display("[TB] FAIL err_drop early: got %b want 0", err_drop); end
                stim = '{7, 15}; expHeads.push_back(4'd7); sendStim(0);
                in_vld = 1'b1;
                in_ptr = 4'd8;
                expQ = '{8'h7F, 8'hF0};
            end
        endcase
        drainCollect(1'b0, 100);
        if (kind == 3) begin
            nVec++; if (err_drop !== 1'b1) begin nMiss++; $display("[TB] FAIL err_drop: got %b want 1", err_drop); end
        end
        nVec++; if (doneAt !== 15) begin nMiss++; $display("[TB] FAIL done cycle: got %0d want 15", doneAt); end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nVec++;
            if (accQ.size() == 0) begin nMiss++; $display("[TB] FAIL pair: got none want %h", e); end
            else begin
                a = accQ.pop_front();
                if (a !== e) begin nMiss++; $display("[TB] FAIL pair: got %h want %h", a, e); end
            end
        end
        nVec++; if (accQ.size() != 0) begin nMiss++; $display("[TB] FAIL extra pairs: got %0d want 0", accQ.size()); end
        while (expHeads.size() > 0) begin
            eh = expHeads.pop_front();
            popHead(v, p);
            nVec++;
            if (v !== 1'b1 || p !== eh) begin nMiss++; $display("[TB] FAIL head: got vld=%b ptr=%0d want ptr=%0d", v, p, eh); end
        end
    endtask

    task automatic test_reset_mid_drain();
        stim = '{7, 15};
        sendStim(0);
        in_vld = 1'b0;
        flush  = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        dump_rdy = 1'b1;
        nVec++; if (busy !== 1'b1) begin nMiss++; $display("[TB] FAIL drain busy: got %b want 1", busy); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        nVec++; if (dump_vld !== 1'b0) begin nMiss++; $display("[TB] FAIL abort dump_vld: got %b want 0", dump_vld); end
        nVec++; if (busy !== 1'b0) begin nMiss++; $display("[TB] FAIL abort busy: got %b want 0", busy); end
        nVec++; if (head_vld !== 1'b0) begin nMiss++; $display("[TB] FAIL abort head_vld: got %b want 0", head_vld); end
        nVec++; if (err_drop !== 1'b0) begin nMiss++; $display("[TB] FAIL abort err_drop: got %b want 0", err_drop); end
        @(negedge clk);
        rst = 1'b0;
        doneAt = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done && doneAt < 0) doneAt = c;
        end
        dump_rdy = 1'b0;
        nVec++; if (doneAt !== -1) begin nMiss++; $display("[TB] FAIL abort done pulse: got cycle %0d want none", doneAt); end
    endtask

    initial begin
        test_reset();
        test_lists(1'b0);
        test_lists(1'b1);
        test_errors(0);
        test_errors(1);
        test_errors(2);
        test_errors(3);
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
